// File: rtl/fifo_read_checker.sv
// fifo_read_checker: pops words from a FIFO read port one at a time and
// holds each word on data_out/data_valid until the downstream stage
// accepts it. Accepted words are counted in word_count.
//
// Optional build macro: SEQ_CHECK_EN
//   When defined, a sequence checker is compiled in. It expects every
//   captured word to be the previous captured word plus one (modulo
//   2^DATA_WIDTH). A mismatch gives a one-cycle seq_error pulse and a
//   saturating err_count increment. When the macro is not defined,
//   seq_error and err_count are tied to zero and no checker state exists.
module fifo_read_checker #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16,
  parameter int ERR_WIDTH  = 8
) (
  input  logic                  read_clk,
  input  logic                  reset,
  input  logic                  read_empty,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  out_ready,
  output logic                  read_en,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  output logic                  seq_error,
  output logic [CNT_WIDTH-1:0]  word_count,
  output logic [ERR_WIDTH-1:0]  err_count
);

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  // POP drives the pop strobe, CAPT is the cycle in which the FIFO data is
  // valid, and HOLD presents the word until the downstream stage accepts it.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_POP  = 2'd1,
    ST_CAPT = 2'd2,
    ST_HOLD = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic                  w_capture;
  logic                  w_accept;
  logic                  r_read_en;
  logic                  r_data_valid;
  logic [DATA_WIDTH-1:0] r_data_out;
  logic [CNT_WIDTH-1:0]  r_word_count;

  // Next-state decode plus the capture and accept strobes for this cycle.
  always_comb begin
    w_next    = r_state;
    w_capture = 1'b0;
    w_accept  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!read_empty) begin
          w_next = ST_POP;
        end else begin
          w_next = ST_IDLE;
        end
      end
      ST_POP: begin
        w_next = ST_CAPT;
      end
      ST_CAPT: begin
        w_capture = 1'b1;
        w_next    = ST_HOLD;
      end
      ST_HOLD: begin
        if (out_ready) begin
          w_accept = 1'b1;
          if (read_empty) begin
            w_next = ST_IDLE;
          end else begin
            w_next = ST_POP;
          end
        end else begin
          w_next = ST_HOLD;
        end
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  // State register and registered outputs. The outputs are decoded from
  // the next state, so they line up exactly with the state they belong to.
  always_ff @(posedge read_clk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_read_en    <= 1'b0;
      r_data_valid <= 1'b0;
      r_data_out   <= {DATA_WIDTH{1'b0}};
      r_word_count <= {CNT_WIDTH{1'b0}};
    end else begin
      r_state      <= w_next;
      r_read_en    <= (w_next == ST_POP);
      r_data_valid <= (w_next == ST_HOLD);
      if (w_capture) begin
        r_data_out <= data_in;
      end
      if (w_accept) begin
        r_word_count <= r_word_count + CNT_ONE;
      end
    end
  end

  assign read_en    = r_read_en;
  assign data_valid = r_data_valid;
  assign data_out   = r_data_out;
  assign word_count = r_word_count;

`ifdef SEQ_CHECK_EN
  localparam logic [DATA_WIDTH-1:0] DATA_ONE = {{(DATA_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [ERR_WIDTH-1:0]  ERR_ONE  = {{(ERR_WIDTH-1){1'b0}}, 1'b1};

  logic [DATA_WIDTH-1:0] r_expected;
  logic                  r_synced;
  logic                  r_seq_error;
  logic [ERR_WIDTH-1:0]  r_err_count;
  logic                  w_mismatch;

  // The error counter sticks at all-ones instead of wrapping.
  function automatic logic [ERR_WIDTH-1:0] sat_inc(input logic [ERR_WIDTH-1:0] value);
    if (&value) begin
      return value;
    end else begin
      return value + ERR_ONE;
    end
  endfunction

  // The first capture after reset only syncs the checker; it is never
  // flagged as a mismatch.
  always_comb begin
    w_mismatch = w_capture && r_synced && (data_in != r_expected);
  end

  // Checker state. Expected is reloaded on every capture, so a single bad
  // word costs one error and the checker realigns to the new sequence.
  always_ff @(posedge read_clk) begin
    if (reset) begin
      r_expected  <= {DATA_WIDTH{1'b0}};
      r_synced    <= 1'b0;
      r_seq_error <= 1'b0;
      r_err_count <= {ERR_WIDTH{1'b0}};
    end else begin
      r_seq_error <= w_mismatch;
      if (w_capture) begin
        r_expected <= data_in + DATA_ONE;
        r_synced   <= 1'b1;
      end
      if (w_mismatch) begin
        r_err_count <= sat_inc(r_err_count);
      end
    end
  end

  assign seq_error = r_seq_error;
  assign err_count = r_err_count;
`else
  assign seq_error = 1'b0;
  assign err_count = {ERR_WIDTH{1'b0}};
`endif

endmodule

// File: tb/tb_fifo_read_checker.sv
// Testbench for fifo_read_checker. The FIFO is modelled as a byte queue
// that pops whenever the DUT strobes read_en and presents the popped word
// in the following cycle (garbage otherwise). A transaction-level model
// tracks the held word, the accepted-word count and the sequence rule.
// Works with or without SEQ_CHECK_EN defined.
module tb_fifo_read_checker;

  localparam int DW = 8;
  localparam int CW = 6;
  localparam int EW = 8;

  logic          read_clk;
  logic          reset;
  logic          read_empty;
  logic [DW-1:0] data_in;
  logic          out_ready;
  logic          read_en;
  logic [DW-1:0] data_out;
  logic          data_valid;
  logic          seq_error;
  logic [CW-1:0] word_count;
  logic [EW-1:0] err_count;

  fifo_read_checker #(
    .DATA_WIDTH(DW),
    .CNT_WIDTH (CW),
    .ERR_WIDTH (EW)
  ) dut (
    .read_clk  (read_clk),
    .reset     (reset),
    .read_empty(read_empty),
    .data_in   (data_in),
    .out_ready (out_ready),
    .read_en   (read_en),
    .data_out  (data_out),
    .data_valid(data_valid),
    .seq_error (seq_error),
    .word_count(word_count),
    .err_count (err_count)
  );

  initial read_clk = 1'b0;
  always #5 read_clk = ~read_clk;

  int n_checks = 0;
  int n_fail   = 0;

  // FIFO model and transaction pipeline
  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] popped_word = 8'h00;
  logic          pop_pending = 1'b0;
  logic [DW-1:0] cap_word    = 8'h00;
  logic          cap_pending = 1'b0;

  // Expected DUT-visible state
  logic          m_holding = 1'b0;
  logic [DW-1:0] m_held    = 8'h00;
  logic [CW-1:0] m_wc      = 6'd0;
  logic [EW-1:0] m_ec      = 8'h00;
  logic          m_seq     = 1'b0;
`ifdef SEQ_CHECK_EN
  logic          m_synced  = 1'b0;
  logic [DW-1:0] m_last    = 8'h00;
`endif

  logic prev_empty = 1'b1;
  logic after_rst  = 1'b0;
  logic chk_period = 1'b0;
  int   last_re    = -1;
  int   cyc        = 0;
  int   n_seq_obs  = 0;
  logic [DW-1:0] next_val = 8'h00;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=0x%0h expected=0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: check outputs at the falling edge, then drive the
  // inputs for the next rising edge and advance the model across it.
  task automatic tick(input logic rst, input logic rdy);
    logic [DW-1:0] succ;
    @(negedge read_clk);
    cyc++;
    check("data_valid", {31'd0, data_valid}, {31'd0, m_holding});
    if (m_holding) check("data_out", {24'd0, data_out}, {24'd0, m_held});
    check("word_count", {26'd0, word_count}, {26'd0, m_wc});
    check("err_count", {24'd0, err_count}, {24'd0, m_ec});
    check("seq_error", {31'd0, seq_error}, {31'd0, m_seq});
    if (after_rst) begin
      check("rst_read_en", {31'd0, read_en}, 32'd0);
      check("rst_data_out", {24'd0, data_out}, 32'd0);
      after_rst = 1'b0;
    end
    if (read_en) begin
      check("rd_after_empty", {31'd0, prev_empty}, 32'd0);
      check("rd_in_hold", {31'd0, m_holding}, 32'd0);
      if (chk_period) begin
        if (last_re >= 0) check("re_period", cyc - last_re, 32'd3);
        last_re = cyc;
      end
    end
    if (seq_error) n_seq_obs++;

    cap_pending = pop_pending;
    cap_word    = popped_word;
    pop_pending = 1'b0;
    data_in     = cap_pending ? cap_word : 8'($urandom);
    read_empty  = (fifo_q.size() == 0);
    reset       = rst;
    out_ready   = rdy;

    m_seq = 1'b0;
    if (rst) begin
      m_holding = 1'b0;
      m_wc      = 6'd0;
      m_ec      = 8'h00;
      after_rst = 1'b1;
`ifdef SEQ_CHECK_EN
      m_synced  = 1'b0;
`endif
    end else begin
      if (m_holding && rdy) begin
        m_holding = 1'b0;
        m_wc      = m_wc + 6'd1;
      end
      if (cap_pending) begin
`ifdef SEQ_CHECK_EN
        succ = m_last + 8'd1;
        if (m_synced && (cap_word != succ)) begin
          m_seq = 1'b1;
          if (m_ec != 8'hFF) m_ec = m_ec + 8'd1;
        end
        m_synced = 1'b1;
        m_last   = cap_word;
`else
        succ = cap_word;
`endif
        m_holding = 1'b1;
        m_held    = cap_word;
      end
    end
    if (read_en) begin
      check("pop_nonempty", {31'd0, fifo_q.size() != 0}, 32'd1);
      if (fifo_q.size() != 0) begin
        popped_word = fifo_q.pop_front();
        pop_pending = !rst;
      end
    end
    prev_empty = read_empty;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b1);
  endtask

  task automatic do_reset();
    tick(1'b1, 1'b1);
    tick(1'b0, 1'b0);
  endtask

  logic [CW-1:0] wc_before;
  int            guard;

  initial begin
    reset = 1'b1; read_empty = 1'b1; out_ready = 1'b0; data_in = 8'h00;

    // Reset state, then an always-empty FIFO never pops
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    for (int i = 0; i < 20; i++) begin
      tick(1'b0, 1'($urandom_range(0, 1)));
      check("empty_no_read", {31'd0, read_en}, 32'd0);
    end

    // Ramp 0x00..0x09 with out_ready high: one pop every 3 cycles
    do_reset();
    for (int i = 0; i < 10; i++) fifo_q.push_back(8'(i));
    chk_period = 1'b1; last_re = -1;
    run(40);
    chk_period = 1'b0;
    check("ramp_wc", {26'd0, word_count}, 32'd10);
    check("ramp_ec", {24'd0, err_count}, 32'd0);

    // Backpressure: 0x42 held for 5 cycles with a further word waiting
    do_reset();
    fifo_q.push_back(8'h42); fifo_q.push_back(8'h43);
    guard = 0;
    while (!m_holding && guard < 10) begin tick(1'b0, 1'b0); guard++; end
    check("hold_reached", {31'd0, m_holding}, 32'd1);
    for (int i = 0; i < 5; i++) tick(1'b0, 1'b0);
    wc_before = word_count;
    check("hold_data", {24'd0, data_out}, 32'h42);
    tick(1'b0, 1'b1);
    tick(1'b0, 1'b0);
    check("hold_wc", {26'd0, word_count}, {26'd0, wc_before + 6'd1});
    run(10);

    // One break in the sequence: 0x10,0x11,0x13,0x14
    do_reset();
    n_seq_obs = 0;
    fifo_q.push_back(8'h10); fifo_q.push_back(8'h11);
    fifo_q.push_back(8'h13); fifo_q.push_back(8'h14);
    run(20);
`ifdef SEQ_CHECK_EN
    check("gap_pulses", n_seq_obs, 32'd1);
    check("gap_ec", {24'd0, err_count}, 32'd1);
`else
    check("gap_pulses", n_seq_obs, 32'd0);
    check("gap_ec", {24'd0, err_count}, 32'd0);
`endif

    // Wrap 0xFE,0xFF,0x00 is a valid sequence
    do_reset();
    n_seq_obs = 0;
    fifo_q.push_back(8'hFE); fifo_q.push_back(8'hFF); fifo_q.push_back(8'h00);
    run(15);
    check("wrap_pulses", n_seq_obs, 32'd0);
    check("wrap_ec", {24'd0, err_count}, 32'd0);

    // Reset during CAPT discards the word; the next word re-syncs
    do_reset();
    n_seq_obs = 0;
    fifo_q.push_back(8'h30); fifo_q.push_back(8'h77); fifo_q.push_back(8'h78);
    guard = 0;
    while (!pop_pending && guard < 10) begin tick(1'b0, 1'b1); guard++; end
    check("capt_reached", {31'd0, pop_pending}, 32'd1);
    tick(1'b1, 1'b1);
    tick(1'b0, 1'b1);
    check("capt_rst_dv", {31'd0, data_valid}, 32'd0);
    check("capt_rst_wc", {26'd0, word_count}, 32'd0);
    run(15);
    check("capt_rst_words", {26'd0, word_count}, 32'd2);
    check("capt_rst_pulses", n_seq_obs, 32'd0);
    check("capt_rst_ec", {24'd0, err_count}, 32'd0);

    // Random words: many errors saturate err_count
    do_reset();
    for (int i = 0; i < 1300; i++) begin
      if (fifo_q.size() < 2) fifo_q.push_back(8'($urandom));
      tick(1'b0, 1'b1);
    end
`ifdef SEQ_CHECK_EN
    check("sat_ec", {24'd0, err_count}, 32'hFF);
`else
    check("sat_ec", {24'd0, err_count}, 32'd0);
`endif

    // Random traffic: mostly incrementing data, random backpressure and resets
    do_reset();
    next_val = 8'($urandom);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 2) == 0) begin
        if ($urandom_range(0, 9) == 0) next_val = 8'($urandom);
        fifo_q.push_back(next_val);
        next_val = next_val + 8'd1;
      end
      tick(1'($urandom_range(0, 199) == 0), 1'($urandom_range(0, 3) != 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
